dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (address, write enable, write data, read data) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the program/data loader or debug access path.
- Performs round-robin arbitration with an optional burst lock.
- Tracks in-flight reads through a fixed-latency tag pipeline so each read response returns only to the requester that issued it.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- RD_LAT, 1, data-memory read latency in cycles, from accepted read to valid mem_rdata; legal range 1..4

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 access request
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  AW  port 0 byte address
- m0_wdata  in  DW  port 0 write data
- m0_lock  in  1  port 0 requests to keep ownership after the current grant
- m0_gnt  out  1  port 0 access accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DW  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after an accepted read

Behaviour:
- **Reset (async, RST=1):**
  - rr_last=1, so port 0 wins the first tie.
  - owner=NONE.
  - Tag pipeline cleared: all valid bits 0.
  - All gnt, rvalid, mem_en and mem_we are 0; rdata outputs are 0.
  - Reset mid-transfer discards in-flight reads; no rvalid is produced for them after reset deasserts.
- **Arbitration (combinational within the cycle):**
  - If owner is locked to port k and mk_req=1, grant k.
  - Otherwise, if exactly one req is high, grant it.
  - If both are high, grant the port not equal to rr_last.
  - At most one gnt is high per cycle.
  - gnt is a same-cycle accept: the request is consumed on the rising edge when req and gnt are both 1.
  - Requesters hold req, we, addr and wdata stable until gnt.
- **Memory drive:**
  - mem_en = m0_gnt | m1_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port.
  - When no port is granted, the address/data outputs are 0.
- **Registered state update on each accepted access:**
  - rr_last <= granted port.
  - If the granted port's lock is 1, owner <= that port; otherwise owner <= NONE.
  - A locked owner whose req drops releases the lock: owner <= NONE. The other port may be granted in that same cycle.
- **Lock states:** NONE, OWN0, OWN1.
  - NONE -> OWNk: accepted access with mk_lock=1.
  - OWNk -> NONE: accepted access with mk_lock=0, or mk_req=0.
- **Read tag pipeline:**
  - RD_LAT stages, each holding {valid, port}.
  - Stage 0 loads {1, granted port} on an accepted read; a write or idle cycle loads {0, x}.
  - The final stage drives responses: mk_rvalid=1 and mk_rdata=mem_rdata when valid and port==k.
  - rdata of the non-selected port is held at its previous value.
  - Back-to-back reads from alternating ports return in issue order, one per cycle, with no bubbles.
- **Throughput and latency:**
  - Throughput is one access per cycle.
  - Writes complete at the accept edge.
  - Read latency seen by a requester is RD_LAT cycles after gnt.
- **Simultaneous events:**
  - A new accept and a returning response in the same cycle are independent.
  - A response to port 0 may coincide with a grant to port 1.
- No error or timeout logic. Out-of-range addresses pass through unchanged.

Test Plan:
- Reset: hold RST=1 with both req=1 -> all gnt, rvalid and mem_en are 0. Release RST -> port 0 granted first.
- Single read: m0 read addr=0x10, memory model returns 0xDEADBEEF, RD_LAT=1 -> m0_gnt in cycle N, m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle N+1, m1_rvalid=0 throughout.
- Contention: both ports request every cycle for 6 cycles with lock=0 -> grants alternate 0,1,0,1,0,1, and mem_addr follows the granted port.
- Lock burst: m1 issues 4 accesses with m1_lock=1 on the first 3 while m0_req is held high -> m1 is granted 4 consecutive cycles, then m0 in the 5th.
- Response routing: alternating reads m0@0x0, m1@0x4, m0@0x8 with RD_LAT=3 -> rvalid on m0, m1, m0 in consecutive cycles 3 cycles after each gnt, each carrying the correct data.
- Reset mid-flight: m0 read granted, RST asserted before data returns (RD_LAT=2) -> no m0_rvalid appears after reset deasserts.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one data-memory port between two requesters: port 0 (CPU load/store)
//   and port 1 (loader / debug). Round-robin arbitration with an optional burst
//   lock. In-flight reads are tracked with a fixed-latency tag pipeline so each
//   read response is routed back only to the port that issued it.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   mK_req/we/addr/     request from port K (held stable until mK_gnt)
//   mK_wdata/mK_lock
//   mK_gnt              same-cycle accept for port K
//   mK_rvalid/mK_rdata  read response for port K (rdata holds between responses)
//   mem_en/we/addr/     memory command, muxed from the granted port
//   mem_wdata
//   mem_rdata           memory read data, valid RD_LAT cycles after a read accept

// Per-port response capture: passes the returning data through on the cycle the
// final tag stage selects this port, and otherwise replays the last value.
module dmem_port_rsp #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          sel,
  input  logic [DW-1:0] mem_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] rdata_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      rdata_q <= '0;
    else if (sel) rdata_q <= mem_rdata;
  end

  assign rvalid = sel;
  assign rdata  = sel ? mem_rdata : rdata_q;
endmodule

module dmem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int NP = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
  } req_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} own_t;

  req_t [NP-1:0]          rq;
  logic [NP-1:0]          req, gnt, rsp_sel, rvalid;
  logic [NP-1:0][DW-1:0]  rdata;
  logic                   gnt_any, gsel, rd_acc;
  logic                   rr_last;
  own_t                   owner;
  logic [RD_LAT-1:0]      vld_pipe;
  logic [RD_LAT-1:0]      port_pipe;

  assign req   = {m1_req, m0_req};
  assign rq[0] = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, lock: m0_lock};
  assign rq[1] = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, lock: m1_lock};

  // Lock owner wins while it keeps requesting; if it drops req the other port
  // arbitrates normally in the same cycle. Ties go to the port not served last.
  always_comb begin
    gnt = '0;
    if (!RST) begin
      if (owner == OWN_0 && req[0])      gnt = 2'b01;
      else if (owner == OWN_1 && req[1]) gnt = 2'b10;
      else if (req == 2'b11)             gnt = rr_last ? 2'b01 : 2'b10;
      else                               gnt = req;
    end
  end

  assign gnt_any = |gnt;
  assign gsel    = gnt[1];
  assign rd_acc  = gnt_any & ~rq[gsel].we;
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];

  assign mem_en    = gnt_any;
  assign mem_we    = gnt_any & rq[gsel].we;
  assign mem_addr  = gnt_any ? rq[gsel].addr  : '0;
  assign mem_wdata = gnt_any ? rq[gsel].wdata : '0;

  // Ownership is decided purely by the access accepted this cycle: with no
  // accept, neither port is requesting, so any lock is released anyway.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_last <= 1'b1;
      owner   <= OWN_NONE;
    end else begin
      if (gnt_any) rr_last <= gsel;
      if (gnt_any && rq[gsel].lock) owner <= gsel ? OWN_1 : OWN_0;
      else                          owner <= OWN_NONE;
    end
  end

  // Read tag pipeline; stage RD_LAT-1 lines up with mem_rdata.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe  <= '0;
      port_pipe <= '0;
    end else begin
      vld_pipe[0]  <= rd_acc;
      port_pipe[0] <= gsel;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        port_pipe[s] <= port_pipe[s-1];
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NP; k++) begin : g_rsp
      assign rsp_sel[k] = vld_pipe[RD_LAT-1] && (port_pipe[RD_LAT-1] == 1'(k));
      dmem_port_rsp #(.DW(DW)) u_rsp (
        .CLK       (CLK),
        .RST       (RST),
        .sel       (rsp_sel[k]),
        .mem_rdata (mem_rdata),
        .rvalid    (rvalid[k]),
        .rdata     (rdata[k])
      );
    end
  endgenerate

  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
endmodule
